// File: rtl/inst_fetch_cache.sv
// Instruction fetch front end: direct-mapped one-word-per-line I-cache over a
// byte-wide RAM port, assembling 32-bit little-endian words on a miss.
module inst_fetch_cache #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_pc,
  output logic        mem_en,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [29:0]      pc_q;
  logic [2:0]       cnt;
  logic             cap_v;
  logic [1:0]       cap_lane;
  logic             done;
  logic [31:0]      word_q;
  logic [31:0]      fill_word;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             issue;
  logic             fill;

  assign req_idx  = req_pc[IDX_W+1:2];
  assign req_tag  = req_pc[31:IDX_W+2];
  assign miss_idx = pc_q[IDX_W-1:0];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  assign req_ready  = (state == S_IDLE) && !flush;
  assign resp_valid = (state == S_RESP) && rdy && !flush;

  // cnt[2] marks all four bytes issued; the fill waits for the last capture
  assign issue  = (state == S_MISS) && rdy && !flush && !cnt[2];
  assign mem_en = issue;
  assign mem_a  = issue ? {pc_q, cnt[1:0]} : 32'd0;

  assign fill = (state == S_MISS) && rdy && !flush &&
                ((cap_v && (cap_lane == 2'd3)) || done);

  always_comb begin
    fill_word = word_q;
    if (cap_v) fill_word[{cap_lane, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      cnt       <= '0;
      cap_v     <= 1'b0;
      cap_lane  <= '0;
      done      <= 1'b0;
      word_q    <= '0;
      resp_inst <= '0;
      resp_pc   <= '0;
      valid     <= '0;
    end else begin
      // RAM latency is fixed, so a byte issued last cycle lands even if rdy dropped
      cap_v <= issue;
      if (issue) cap_lane <= cnt[1:0];
      if (cap_v) word_q <= fill_word;
      if (cap_v && (cap_lane == 2'd3)) done <= 1'b1;

      if (rdy) begin
        if (flush) begin
          state <= S_IDLE;
          cnt   <= '0;
          done  <= 1'b0;
        end else begin
          case (state)
            S_IDLE: begin
              if (req_valid) begin
                if (hit) begin
                  resp_inst <= data_mem[req_idx];
                  resp_pc   <= {req_pc[31:2], 2'b00};
                  state     <= S_RESP;
                end else begin
                  pc_q  <= req_pc[31:2];
                  cnt   <= '0;
                  done  <= 1'b0;
                  state <= S_MISS;
                end
              end
            end
            S_MISS: begin
              if (issue) cnt <= cnt + 3'd1;
              if (fill) begin
                valid[miss_idx] <= 1'b1;
                resp_inst       <= fill_word;
                resp_pc         <= {pc_q, 2'b00};
                done            <= 1'b0;
                state           <= S_RESP;
              end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_mem[miss_idx]  <= pc_q[29:IDX_W];
      data_mem[miss_idx] <= fill_word;
    end
  end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Directed bench for inst_fetch_cache: misses, hits, conflict eviction,
// flush cancellation and rdy stalls against a byte RAM model.
module tb_inst_fetch_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] resp_pc;
  logic        mem_en;
  logic [31:0] mem_a;
  logic [7:0]  mem_din = 8'h00;

  logic [7:0]  ram [1024];
  int          checks = 0;
  int          errors = 0;

  inst_fetch_cache #(.IDX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_pc(resp_pc),
    .mem_en(mem_en), .mem_a(mem_a), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_din <= ram[mem_a[9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    for (int b = 0; b < 4; b++) ram[addr + b] = w[8*b +: 8];
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [31:0] inst);
    req_pc = pc; req_valid = 1'b1; #1;
    check("miss_req_ready", req_ready, 1);
    step(); req_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      check("miss_mem_en", mem_en, 1);
      check("miss_mem_a", mem_a, pc + k);
      step();
    end
    check("miss_gap_en", mem_en, 0);
    check("miss_gap_rv", resp_valid, 0);
    step();
    check("miss_resp_valid", resp_valid, 1);
    check("miss_resp_inst", resp_inst, inst);
    check("miss_resp_pc", resp_pc, pc);
    step();
    check("miss_after_rv", resp_valid, 0);
    check("miss_after_ready", req_ready, 1);
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] inst);
    req_pc = pc; req_valid = 1'b1; #1;
    check("hit_req_ready", req_ready, 1);
    step(); req_valid = 1'b0; #1;
    check("hit_mem_en", mem_en, 0);
    check("hit_resp_valid", resp_valid, 1);
    check("hit_resp_inst", resp_inst, inst);
    check("hit_resp_pc", resp_pc, pc);
    check("hit_busy_ready", req_ready, 0);
    step();
    check("hit_after_rv", resp_valid, 0);
    check("hit_after_ready", req_ready, 1);
  endtask

  initial begin
    int activity;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
    put_word(32'h100, 32'hDEAD_BEEF);
    put_word(32'h040, 32'h1234_5678);
    put_word(32'h080, 32'hCAFE_F00D);
    put_word(32'h200, 32'h0BAD_C0DE);

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0;
    step(); step(); step();
    rst = 1'b0; #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_inst", resp_inst, 0);
    check("rst_resp_pc", resp_pc, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_req_ready", req_ready, 1);

    do_miss(32'h0, 32'h0010_0513);
    do_hit(32'h0, 32'h0010_0513);
    do_hit(32'h0, 32'h0010_0513);

    // same index, different tag: evicts and refetches
    do_miss(32'h100, 32'hDEAD_BEEF);
    do_miss(32'h0, 32'h0010_0513);
    do_hit(32'h0, 32'h0010_0513);

    // flush mid-miss
    req_pc = 32'h40; req_valid = 1'b1;
    step(); req_valid = 1'b0; #1;
    check("fl_addr0", mem_a, 32'h40);
    step();
    check("fl_addr1", mem_a, 32'h41);
    step(); flush = 1'b1; #1;
    check("fl_mem_en", mem_en, 0);
    check("fl_ready_low", req_ready, 0);
    check("fl_rv", resp_valid, 0);
    step(); flush = 1'b0; #1;
    check("fl_ready_back", req_ready, 1);
    activity = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid || mem_en) activity++;
      step();
    end
    check("fl_quiet", activity, 0);
    do_miss(32'h40, 32'h1234_5678);

    // rdy low for three cycles starting at T+2
    req_pc = 32'h80; req_valid = 1'b1;
    step(); req_valid = 1'b0; #1;
    check("rdy_addr0", mem_a, 32'h80);
    step(); rdy = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("rdy_gap_en", mem_en, 0);
      check("rdy_gap_rv", resp_valid, 0);
      if (i < 2) step();
    end
    step(); rdy = 1'b1; #1;
    for (int k = 1; k < 4; k++) begin
      check("rdy_mem_en", mem_en, 1);
      check("rdy_mem_a", mem_a, 32'h80 + k);
      step();
    end
    check("rdy_t8_rv", resp_valid, 0);
    step();
    check("rdy_t9_rv", resp_valid, 1);
    check("rdy_inst", resp_inst, 32'hCAFE_F00D);
    step();
    do_hit(32'h80, 32'hCAFE_F00D);

    // flush while the hit response is due
    req_pc = 32'h0; req_valid = 1'b1;
    step(); req_valid = 1'b0; flush = 1'b1; #1;
    check("flresp_rv", resp_valid, 0);
    step(); flush = 1'b0; #1;
    check("flresp_ready", req_ready, 1);
    check("flresp_rv_after", resp_valid, 0);

    // flush beats a simultaneous request
    req_pc = 32'h200; req_valid = 1'b1; flush = 1'b1; #1;
    check("flreq_ready", req_ready, 0);
    step(); req_valid = 1'b0; flush = 1'b0; #1;
    activity = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || mem_en) activity++;
      step();
    end
    check("flreq_quiet", activity, 0);
    do_miss(32'h200, 32'h0BAD_C0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_cache.md
# inst_fetch_cache

Instruction-side memory front end between the fetch stage and the byte-wide unified RAM port. Accepts word-aligned fetch addresses, serves hits from a direct-mapped one-word-per-line instruction cache in one cycle, and on a miss assembles a 32-bit little-endian instruction from four sequential byte reads. Returns the instruction and its PC to the fetch stage through a valid/ready handshake and supports a flush for branch redirects.

## Interface
- IDX_W, default 6: cache index width; 2^IDX_W lines of one 32-bit word each.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes the block.
- flush  in  1  cancel any in-flight fetch (branch redirect).
- req_valid  in  1  fetch request present.
- req_pc  in  32  fetch address; bits [1:0] ignored (treated as 0).
- req_ready  out  1  block can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse: resp_inst/resp_pc valid.
- resp_inst  out  32  fetched instruction.
- resp_pc  out  32  address of resp_inst (bits [1:0] = 0).
- mem_en  out  1  byte read issued this cycle.
- mem_a  out  32  byte address of the read.
- mem_din  in  8  read data; valid the cycle after mem_en was high.

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. Per line: valid bit, tag, 32-bit data.
- States: IDLE, MISS, RESP.
- IDLE: req_ready = 1 when flush = 0. Request accepted on req_valid & req_ready & rdy. Lookup combinational in the acceptance cycle.
  - Hit: load resp_inst/resp_pc, go RESP.
  - Miss: latch pc, byte counter = 0, go MISS.
- MISS: each rdy-high cycle drive mem_en = 1, mem_a = {pc[31:2],2'b00} + counter, counter++. After counter reaches 3 stop issuing. mem_din captured into byte lane k (k = issue order, lane 0 = bits [7:0]) the cycle after byte k was issued. After lane 3 is captured: write line (valid = 1, tag, data), load resp_inst/resp_pc, go RESP.
- RESP: resp_valid = 1 for exactly one cycle, req_ready = 0, then IDLE. resp_inst/resp_pc hold until next response.
- flush (rdy high): any state goes to IDLE next cycle; no resp_valid for the cancelled fetch (including one already in RESP); pending byte captures discarded; cache contents kept; no line written for a cancelled miss. flush with req_valid in the same cycle: flush wins, request not accepted.
- rdy low: state, counter, and cache hold; mem_en = 0; resp_valid = 0; no request accepted. A byte issued in the last rdy-high cycle is still captured on the next cycle (RAM latency fixed).
- mem_en = 0 in IDLE and RESP.

## Timing
- Reset: state IDLE, all valid bits 0, resp_valid 0, resp_inst 0, resp_pc 0, mem_en 0, mem_a 0, counter 0, req_ready 1 from the first post-reset cycle.
- Hit: accept at T, resp_valid at T+1, req_ready again at T+2.
- Miss (rdy high throughout): accept at T; mem_a = pc..pc+3 at T+1..T+4; bytes captured T+2..T+5; line written and resp_valid at T+6.
- Each rdy-low cycle during MISS extends the miss latency by one cycle.
- Back-to-back hits: one response every 2 cycles.

## Test plan
- After reset, request 0x0000_0000 with RAM bytes 0x13,0x05,0x10,0x00 -> mem_a 0,1,2,3 on consecutive cycles, resp_valid 6 cycles after acceptance, resp_inst 0x0010_0513, resp_pc 0x0.
- Re-request 0x0000_0000 -> mem_en stays 0, resp_valid next cycle, resp_inst 0x0010_0513.
- Conflict: request 0x100 (same index as 0x0 when IDX_W = 6) -> miss, 4 byte reads; then 0x0 -> miss again (line evicted).
- Assert flush at T+3 of a miss to 0x40 -> no resp_valid, req_ready back at T+4, subsequent request to 0x40 misses (line not written).
- Drop rdy for 3 cycles at T+2 of a miss -> mem_en 0 during the gap, addresses resume in order, correct word, resp_valid at T+9.
- req_valid with flush in the same cycle in IDLE -> request not accepted, no memory activity.
